pixel_plot_buffer: RTL and testbench

Elastic buffer between the Reuleaux-triangle drawer and the framebuffer write port. Captures every `vga_plot` request (x, y, colour) from the drawer, discards off-screen coordinates, queues on-screen pixels in a small FIFO, and drains them to the framebuffer over a valid/ack handshake. Sticky status and counters let the bench and the top level confirm that every plotted pixel reached memory.

---
 rtl/pixel_plot_buffer_if.sv | 24 ++
 rtl/pixel_plot_buffer.sv | 122 ++++++++++++
 tb/tb_pixel_plot_buffer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pixel_plot_buffer_if.sv
// Drawer-to-framebuffer pixel bus: plot requests in, framebuffer writes out.
// The buffer sits on the slave side; the drawer/framebuffer pair is the master.
interface pixel_plot_buffer_if;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       in_ready;
  logic [7:0] fb_x;
  logic [6:0] fb_y;
  logic [2:0] fb_colour;
  logic       fb_we;
  logic       fb_ack;

  modport master (
    output vga_x, vga_y, vga_colour, vga_plot, fb_ack,
    input  in_ready, fb_x, fb_y, fb_colour, fb_we
  );

  modport slave (
    input  vga_x, vga_y, vga_colour, vga_plot, fb_ack,
    output in_ready, fb_x, fb_y, fb_colour, fb_we
  );
endinterface

// File: rtl/pixel_plot_buffer.sv
// Elastic pixel FIFO between the Reuleaux drawer and the framebuffer write port.
// Off-screen plots are clipped and counted; on-screen plots are queued and drained show-ahead.
module pixel_plot_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned X_MAX = 159,
  parameter int unsigned Y_MAX = 119
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  pixel_plot_buffer_if.slave    bus,
  output logic                  empty,
  output logic                  overflow,
  output logic [15:0]           clip_count,
  output logic [15:0]           plot_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [7:0]  X_LIM = 8'(X_MAX);
  localparam logic [6:0]  Y_LIM = 7'(Y_MAX);
  localparam logic [15:0] SAT = 16'hFFFF;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   clip_count_q, clip_count_d;
  logic [15:0]   plot_count_q, plot_count_d;

  logic   in_bounds, valid, pop, push, clip, drop, ready;
  entry_t head;

  assign in_bounds = (bus.vga_x <= X_LIM) && (bus.vga_y <= Y_LIM);
  assign valid     = (count_q != '0);
  assign pop       = valid && bus.fb_ack;
  // A pop on a full FIFO frees the slot the same cycle, so full-rate streaming never stalls.
  assign ready     = (count_q < FULL) || pop;
  assign push      = bus.vga_plot && in_bounds && ready;
  assign clip      = bus.vga_plot && !in_bounds;
  assign drop      = bus.vga_plot && in_bounds && !ready;
  assign head      = mem_q[rd_ptr_q];

  assign bus.in_ready  = ready;
  assign bus.fb_we     = valid;
  assign bus.fb_x      = valid ? head.x      : '0;
  assign bus.fb_y      = valid ? head.y      : '0;
  assign bus.fb_colour = valid ? head.colour : '0;
  assign empty         = !valid;
  assign overflow      = overflow_q;
  assign clip_count    = clip_count_q;
  assign plot_count    = plot_count_q;

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    clip_count_d = clip_count_q;
    plot_count_d = plot_count_q;
    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      overflow_d   = 1'b0;
      clip_count_d = '0;
      plot_count_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{x: bus.vga_x, y: bus.vga_y, colour: bus.vga_colour};
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + (AW+1)'(1);
      end else if (pop && !push) begin
        count_d = count_q - (AW+1)'(1);
      end
      if (drop) begin
        overflow_d = 1'b1;
      end
      if (clip && (clip_count_q != SAT)) begin
        clip_count_d = clip_count_q + 16'd1;
      end
      if (pop && (plot_count_q != SAT)) begin
        plot_count_d = plot_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      clip_count_q <= '0;
      plot_count_q <= '0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      clip_count_q <= clip_count_d;
      plot_count_q <= plot_count_d;
    end
  end

endmodule

// File: tb/tb_pixel_plot_buffer.sv
// Directed bench for pixel_plot_buffer; a scoreboard queue holds expected pixels
// and a negedge monitor checks every framebuffer handshake against it.
module tb_pixel_plot_buffer;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        empty;
  logic        overflow;
  logic [15:0] clip_count;
  logic [15:0] plot_count;

  pixel_plot_buffer_if bus();

  pixel_plot_buffer #(.DEPTH(8), .X_MAX(159), .Y_MAX(119)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .bus        (bus),
    .empty      (empty),
    .overflow   (overflow),
    .clip_count (clip_count),
    .plot_count (plot_count)
  );

  logic [17:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One plot cycle: check in_ready before the edge and record the pixel if it should be queued.
  task automatic apply_stimulus(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                                input bit exp_push, input bit exp_ready);
    bus.vga_x      = x;
    bus.vga_y      = y;
    bus.vga_colour = c;
    bus.vga_plot   = 1'b1;
    @(negedge clk);
    check_output("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    if (exp_push) exp_q.push_back({x, y, c});
    step();
    bus.vga_plot = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (!empty && n < budget) begin
      step();
      n++;
    end
    check_output("drain_done", 32'(empty), 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.fb_we && bus.fb_ack) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_pixel: got %0h expected none", {bus.fb_x, bus.fb_y, bus.fb_colour});
      end else begin
        check_output("fb_pixel", 32'({bus.fb_x, bus.fb_y, bus.fb_colour}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    clear          = 1'b0;
    bus.vga_x      = '0;
    bus.vga_y      = '0;
    bus.vga_colour = '0;
    bus.vga_plot   = 1'b0;
    bus.fb_ack     = 1'b0;
    repeat (2) step();
    check_output("rst_fb_we", 32'(bus.fb_we), 32'd0);
    check_output("rst_fb_xyc", 32'({bus.fb_x, bus.fb_y, bus.fb_colour}), 32'd0);
    check_output("rst_empty", 32'(empty), 32'd1);
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_output("rst_overflow", 32'(overflow), 32'd0);
    check_output("rst_counts", {clip_count, plot_count}, 32'd0);
    rst = 1'b0;
    step();

    // Streaming with ack held: each pixel visible one cycle after its push.
    bus.fb_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(8'(10 + i), 7'd20, 3'd3, 1'b1, 1'b1);
      if (i == 0) check_output("first_latency_we", 32'(bus.fb_we), 32'd1);
    end
    check_output("stream_last_we", 32'(bus.fb_we), 32'd1);
    step();
    check_output("stream_empty", 32'(empty), 32'd1);
    check_output("stream_plot_count", 32'(plot_count), 32'd4);

    // Fill to full with no ack, then a simultaneous push+pop at full.
    bus.fb_ack = 1'b0;
    for (int i = 0; i < 8; i++) apply_stimulus(8'(i), 7'd5, 3'(i), 1'b1, 1'b1);
    check_output("full_not_empty", 32'(empty), 32'd0);
    bus.fb_ack = 1'b1;
    apply_stimulus(8'd50, 7'd50, 3'd5, 1'b1, 1'b1);
    bus.fb_ack = 1'b0;
    check_output("full_pushpop_overflow", 32'(overflow), 32'd0);
    apply_stimulus(8'd60, 7'd1, 3'd1, 1'b0, 1'b0);
    apply_stimulus(8'd61, 7'd2, 3'd2, 1'b0, 1'b0);
    check_output("overflow_set", 32'(overflow), 32'd1);
    bus.fb_ack = 1'b1;
    wait_empty(20);
    check_output("drain_plot_count", 32'(plot_count), 32'd13);

    // Clipping boundaries.
    apply_stimulus(8'd160, 7'd0,   3'd1, 1'b0, 1'b1);
    apply_stimulus(8'd0,   7'd120, 3'd2, 1'b0, 1'b1);
    apply_stimulus(8'd159, 7'd119, 3'd7, 1'b1, 1'b1);
    wait_empty(10);
    check_output("clip_count", 32'(clip_count), 32'd2);
    check_output("clip_plot_count", 32'(plot_count), 32'd14);

    // Clear with queued entries, sticky overflow and a concurrent plot.
    bus.fb_ack = 1'b0;
    for (int i = 0; i < 5; i++) apply_stimulus(8'(100 + i), 7'd9, 3'd4, 1'b1, 1'b1);
    check_output("pre_clear_overflow", 32'(overflow), 32'd1);
    clear          = 1'b1;
    bus.vga_x      = 8'd7;
    bus.vga_y      = 7'd7;
    bus.vga_colour = 3'd1;
    bus.vga_plot   = 1'b1;
    step();
    clear        = 1'b0;
    bus.vga_plot = 1'b0;
    exp_q.delete();
    check_output("clear_empty", 32'(empty), 32'd1);
    check_output("clear_overflow", 32'(overflow), 32'd0);
    check_output("clear_counts", {clip_count, plot_count}, 32'd0);
    bus.fb_ack = 1'b1;
    repeat (3) step();

    // Asynchronous reset between edges with 3 entries queued.
    bus.fb_ack = 1'b0;
    for (int i = 0; i < 3; i++) apply_stimulus(8'(20 + i), 7'd30, 3'd6, 1'b1, 1'b1);
    apply_stimulus(8'd200, 7'd0, 3'd0, 1'b0, 1'b1);
    check_output("pre_rst_clip", 32'(clip_count), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check_output("async_rst_fb_we", 32'(bus.fb_we), 32'd0);
    check_output("async_rst_clip", 32'(clip_count), 32'd0);
    step();
    rst        = 1'b0;
    bus.fb_ack = 1'b1;
    repeat (4) step();
    check_output("post_rst_empty", 32'(empty), 32'd1);

    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
